// File: rtl/sar_adc_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sar_adc_ctrl
// Description : Successive-approximation ADC controller. A start request in
//               IDLE opens the sample/hold window for SAMPLE_CYC cycles, then
//               one bit per SETTLE cycles is resolved MSB first against the
//               comparator. The final code is loaded into data_out together
//               with a single-cycle done pulse.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-high reset
//               start    - conversion request (honoured only in IDLE)
//               cmp_in   - comparator, 1 = analog input >= DAC voltage
//               sample   - sample/hold control to the analog front end
//               dac_code - trial code to the feedback DAC
//               busy     - high in every state except IDLE
//               done     - one-cycle pulse, data_out has just been updated
//               data_out - last completed conversion result
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module sar_adc_ctrl #(
    parameter int WIDTH      = 32,
    parameter int SAMPLE_CYC = 4,
    parameter int SETTLE     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cmp_in,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    localparam int c_BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SAMPLE = 2'd1;
    localparam logic [1:0] c_TRIAL  = 2'd2;
    localparam logic [1:0] c_DONE   = 2'd3;

    // Down-counters are preloaded with N-1 so they expire on the Nth edge.
    localparam logic [7:0]         c_SAMPLE_LOAD = 8'(SAMPLE_CYC - 1);
    localparam logic [7:0]         c_SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [c_BIT_W-1:0] c_MSB_IDX     = c_BIT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_MSB_CODE    = WIDTH'(1) << (WIDTH - 1);

    logic [1:0]         r_state, w_state_nxt;
    logic [7:0]         r_cnt, w_cnt_nxt;
    logic [c_BIT_W-1:0] r_bit, w_bit_nxt;
    logic [WIDTH-1:0]   r_code, w_code_nxt;
    logic               r_sample, w_sample_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [WIDTH-1:0]   r_data, w_data_nxt;

    logic [WIDTH-1:0]   w_bit_mask;
    logic [WIDTH-1:0]   w_kept;

    // Mask of the bit under test; the next trial bit is simply this mask
    // shifted right, so no k-1 arithmetic is needed on the code path.
    assign w_bit_mask = WIDTH'(1) << r_bit;
    assign w_kept     = cmp_in ? r_code : (r_code & ~w_bit_mask);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_code_nxt   = r_code;
        w_sample_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_data_nxt   = r_data;

        case (r_state)
            c_IDLE: begin
                w_code_nxt = '0;
                if (start) begin
                    w_state_nxt  = c_SAMPLE;
                    w_cnt_nxt    = c_SAMPLE_LOAD;
                    w_sample_nxt = 1'b1;
                    w_busy_nxt   = 1'b1;
                end
            end

            c_SAMPLE: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == 8'd0) begin
                    w_state_nxt = c_TRIAL;
                    w_cnt_nxt   = c_SETTLE_LOAD;
                    w_bit_nxt   = c_MSB_IDX;
                    w_code_nxt  = c_MSB_CODE;
                end else begin
                    w_cnt_nxt    = r_cnt - 8'd1;
                    w_sample_nxt = 1'b1;
                end
            end

            c_TRIAL: begin
                w_busy_nxt = 1'b1;
                if (r_cnt != 8'd0) begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end else if (r_bit == '0) begin
                    // Last decision: the bit index stays at 0, never wraps.
                    w_state_nxt = c_DONE;
                    w_data_nxt  = w_kept;
                    w_done_nxt  = 1'b1;
                    w_code_nxt  = '0;
                end else begin
                    w_code_nxt = w_kept | (w_bit_mask >> 1);
                    w_bit_nxt  = r_bit - c_BIT_W'(1);
                    w_cnt_nxt  = c_SETTLE_LOAD;
                end
            end

            c_DONE: begin
                // start is deliberately ignored here; IDLE is always visited.
                w_state_nxt = c_IDLE;
                w_code_nxt  = '0;
            end

            default: begin
                w_state_nxt = c_IDLE;
                w_code_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= 8'd0;
            r_bit    <= '0;
            r_code   <= '0;
            r_sample <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_code   <= w_code_nxt;
            r_sample <= w_sample_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_data   <= w_data_nxt;
        end
    end

    assign sample   = r_sample;
    assign dac_code = r_code;
    assign busy     = r_busy;
    assign done     = r_done;
    assign data_out = r_data;

endmodule
`default_nettype wire
